// File: rtl/uart_32_bit_rx.sv
// ============================================================================
// Module   : uart_32_bit_rx
// Purpose  : UART receiver for 32-data-bit frames with a one-entry valid/ready
//            output register, framing and overrun reporting.
//            Define UART_32_BIT_RX_PARITY_EN for an even-parity bit after DATA.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_32_bit_rx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        rx,
    output logic [31:0] rdata_out,
    output logic        rvalid_out,
    input  logic        rready_in,
    output logic        frame_err_out,
    output logic        overrun_out,
    output logic        busy_out
`ifdef UART_32_BIT_RX_PARITY_EN
    ,
    output logic        parity_err_out
`endif
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_q;
    logic [2:0]             r_state;
    logic [c_CNT_W-1:0]     r_clk_cnt;
    logic [4:0]             r_bit_cnt;
    logic [31:0]            r_shift;

    logic [2:0]             w_state_nxt;
    logic [c_CNT_W-1:0]     w_clk_cnt_nxt;
    logic [4:0]             w_bit_cnt_nxt;
    logic                   w_rx;
    logic                   w_tick;
    logic                   w_shift_en;
    logic                   w_done;
    logic                   w_frame_err;
    logic                   w_hs;
    logic                   w_drop;
    logic                   w_par_ok;

`ifdef UART_32_BIT_RX_PARITY_EN
    logic                   r_par_bad;
    logic                   w_par_err;
    assign w_par_ok = ~r_par_bad;
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_rx     = r_sync[SYNC_STAGES-1];
    assign w_tick   = (r_clk_cnt == c_BIT_LAST);
    assign busy_out = (r_state != c_IDLE);
    assign w_hs     = rvalid_out & rready_in;
    assign w_drop   = w_done & rvalid_out & ~rready_in;

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_en    = 1'b0;
        w_done        = 1'b0;
        w_frame_err   = 1'b0;
`ifdef UART_32_BIT_RX_PARITY_EN
        w_par_err     = 1'b0;
`endif
        case (r_state)
            c_IDLE: begin
                w_clk_cnt_nxt = '0;
                if (r_rx_q && !w_rx) begin
                    w_state_nxt = c_START;
                end
            end
            c_START: begin
                // Half-bit wait puts every later sample at a bit centre
                if (r_clk_cnt == c_HALF_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_cnt_nxt = 5'd0;
                    w_state_nxt   = w_rx ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (w_tick) begin
                    w_clk_cnt_nxt = '0;
                    w_shift_en    = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd31) begin
`ifdef UART_32_BIT_RX_PARITY_EN
                        w_state_nxt = c_PARITY;
`else
                        w_state_nxt = c_STOP;
`endif
                    end
                end
            end
`ifdef UART_32_BIT_RX_PARITY_EN
            c_PARITY: begin
                if (w_tick) begin
                    w_clk_cnt_nxt = '0;
                    w_par_err     = (w_rx != ^r_shift);
                    w_state_nxt   = c_STOP;
                end
            end
`endif
            c_STOP: begin
                if (w_tick) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = c_IDLE;
                    w_done        = w_rx & w_par_ok;
                    w_frame_err   = ~w_rx;
                end
            end
            default: begin
                w_clk_cnt_nxt = '0;
                w_state_nxt   = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_sync    <= '1;
            r_rx_q    <= 1'b1;
            r_state   <= c_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
            r_rx_q    <= w_rx;
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            if (w_shift_en) begin
                r_shift <= {w_rx, r_shift[31:1]};
            end
        end
    end

    // One-entry output register: a completion that cannot be stored is dropped
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rdata_out     <= '0;
            rvalid_out    <= 1'b0;
            overrun_out   <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            frame_err_out <= w_frame_err;
            if (w_done && (!rvalid_out || rready_in)) begin
                rdata_out  <= r_shift;
                rvalid_out <= 1'b1;
            end else if (w_hs) begin
                rvalid_out <= 1'b0;
            end
            if (w_drop) begin
                overrun_out <= 1'b1;
            end else if (w_hs) begin
                overrun_out <= 1'b0;
            end
        end
    end

`ifdef UART_32_BIT_RX_PARITY_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_par_bad      <= 1'b0;
            parity_err_out <= 1'b0;
        end else begin
            parity_err_out <= w_par_err;
            if (w_par_err) begin
                r_par_bad <= 1'b1;
            end else if (r_state == c_IDLE) begin
                r_par_bad <= 1'b0;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/uart_32_bit_rx.md
Name: uart_32_bit_rx

Overview:
Serial receiver that sits directly downstream of the UART rx pin and upstream of the AXI4-Lite UART 32-bit slave's read-data register. It deserialises one 32-data-bit UART frame (start, 32 data bits, optional parity, stop) into a 32-bit word. It presents the word on a valid/ready handshake that the slave consumes on an AR/R transaction. It also reports framing and overrun errors.

Parameters:
CLKS_PER_BIT, 10417, aclk cycles per bit (100 MHz / 9600 baud); must be >= 4
SYNC_STAGES, 2, flops in the rx metastability synchroniser; must be >= 2

Ports:
aclk  input  1  system clock, rising edge
areset  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to aclk
rdata_out  output  32  received word; first data bit received lands in bit 0
rvalid_out  output  1  rdata_out holds an unconsumed word
rready_in  input  1  consumer accepts the word when rvalid_out && rready_in
frame_err_out  output  1  one-cycle pulse: stop bit sampled low
overrun_out  output  1  sticky: a completed frame was dropped; cleared on the next accepted handshake
busy_out  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (areset=1, async): state=IDLE, all counters 0, synchroniser flops 1, rdata_out=0, rvalid_out=0, frame_err_out=0, overrun_out=0, busy_out=0. A reset mid-frame abandons the frame; no partial word is ever delivered.
- rx passes through SYNC_STAGES flops. One extra registered copy (rx_q) is kept for edge detection.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the option).
- IDLE: a falling edge (rx_q=1, synced rx=0) -> START with clk_cnt=0. A line held low never retriggers.
- START: count CLKS_PER_BIT/2 cycles (integer division), then sample. If low -> DATA with clk_cnt=0 and bit_cnt=0. If high, treat as a glitch -> IDLE, no flags.
- DATA: sample every CLKS_PER_BIT cycles. This places each sample at the bit centre.
- DATA shift order: each sample shifts into a 32-bit shift register LSB-first, so the first bit ends at bit 0.
- DATA exit: after the 32nd sample (bit_cnt 31 -> wrap) -> STOP.
- STOP: sample after CLKS_PER_BIT cycles. If high, the frame is complete. If low, pulse frame_err_out for 1 cycle, discard the word, -> IDLE.
- Completion latency: rdata_out and rvalid_out update on the clock edge after the stop-bit sample. The FSM returns to IDLE in the same cycle.
- Output register, one entry:
  - rvalid_out stays high until the handshake.
  - rdata_out is stable while rvalid_out=1.
  - Handshake with no completion that cycle: rvalid_out <- 0 next cycle.
  - Completion while rvalid_out=0: load the word, rvalid_out <- 1.
  - Completion in the same cycle as a handshake: load the new word, rvalid_out stays 1, no overrun.
  - Completion while rvalid_out=1 and rready_in=0: drop the new word, keep the old one, set overrun_out.
  - overrun_out clears on the next handshake. If a drop and a handshake occur in the same cycle, the set wins.
- Counters: clk_cnt is $clog2(CLKS_PER_BIT) bits and resets to 0 on every state entry. bit_cnt is 5 bits.
- busy_out = (state != IDLE).

Optional Feature:
Macro UART_32_BIT_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one even-parity bit over the 32 data bits.
  - Adds output port parity_err_out (1 bit, reset 0), a one-cycle pulse issued on mismatch.
  - On mismatch the FSM still checks the stop bit. The word is discarded and rvalid_out and overrun_out are unaffected.
  - Frame length is 35 bit times.
- Undefined: no PARITY state, no parity_err_out port, frame length is 34 bit times.

Test Plan:
- CLKS_PER_BIT=16; send start, 32'hF0B4A596 LSB-first, stop, with rready_in=1 -> rvalid_out high for exactly 1 cycle with rdata_out=32'hF0B4A596; 1 cycle after the stop sample; frame_err_out=0.
- rready_in=0; send 32'h12345678, then 32'hDEADBEEF -> rdata_out stays 32'h12345678 and overrun_out=1. Then raise rready_in for 1 cycle -> rvalid_out=0 and overrun_out=0.
- Send 32'h00000001 with the stop bit forced low -> frame_err_out pulses once, rvalid_out stays 0. Hold rx low for 100 cycles -> busy_out stays 0 (no retrigger).
- rx low pulse of 5 cycles (< CLKS_PER_BIT/2) -> FSM returns to IDLE, no flags, rvalid_out=0.
- Assert areset at data bit 10 of a frame, release, then send a clean 32'hA5A5A5A5 -> only 32'hA5A5A5A5 is delivered.
- With UART_32_BIT_RX_PARITY_EN defined: send 32'h00000003 with parity bit 0 -> accepted. Send the same word with parity bit 1 -> parity_err_out pulses once, no rvalid_out.
